// File: rtl/z4ml_inv_serial.sv
// rtl/z4ml_inv_serial.sv - bit-serial inverse of the z4ml adder (A = S - B - CIN), optional Z4ML_INV_FAST_EN
// Recovers addend A from sum S, known addend B and carry-in; flags sums no legal A can reach.
// Defining Z4ML_INV_FAST_EN replaces the serial subtract with a single-cycle (W+2)-bit subtract.

module z4ml_inv_serial #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W:0]   in_s,
    input  logic [W-1:0] in_b,
    input  logic         in_cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_a,
    output logic         out_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [W:0] s_reg;
    logic [W:0] b_reg;
    logic       borrow;
    logic       last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = RUN;
            RUN:     if (last)      state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

`ifdef Z4ML_INV_FAST_EN
    // The extra top bit of diff is the final borrow; bit W is the overflow of A.
    logic [W+1:0] diff;

    assign diff = {1'b0, s_reg} - {1'b0, b_reg} - (W+2)'(borrow);
    assign last = 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_reg   <= '0;
            b_reg   <= '0;
            borrow  <= 1'b0;
            out_a   <= '0;
            out_err <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            s_reg  <= in_s;
            b_reg  <= {1'b0, in_b};
            borrow <= in_cin;
        end else if (state == RUN) begin
            out_a   <= diff[W-1:0];
            out_err <= diff[W+1] | diff[W];
        end
    end
`else
    localparam int CW = $clog2(W + 2);

    logic [CW-1:0] cnt;
    logic [W-1:0]  d_reg;
    logic          d_bit;
    logic          borrow_nxt;

    // Operands shift right so the current bit is always at index 0.
    assign d_bit      = s_reg[0] ^ b_reg[0] ^ borrow;
    assign borrow_nxt = (~s_reg[0] & (b_reg[0] | borrow)) | (b_reg[0] & borrow);
    assign last       = (cnt == CW'(W));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_reg   <= '0;
            b_reg   <= '0;
            borrow  <= 1'b0;
            cnt     <= '0;
            d_reg   <= '0;
            out_a   <= '0;
            out_err <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            s_reg  <= in_s;
            b_reg  <= {1'b0, in_b};
            borrow <= in_cin;
            cnt    <= '0;
            d_reg  <= '0;
        end else if (state == RUN) begin
            s_reg  <= s_reg >> 1;
            b_reg  <= b_reg >> 1;
            borrow <= borrow_nxt;
            cnt    <= cnt + CW'(1);
            // d bits enter at the top; after W shifts d_reg holds d[W-1:0].
            d_reg  <= (d_reg >> 1) | (W'(d_bit) << (W - 1));
            if (last) begin
                out_a   <= d_reg;
                out_err <= borrow_nxt | d_bit;
            end
        end
    end
`endif

endmodule

// File: tb/tb_z4ml_inv_serial.sv
// tb/tb_z4ml_inv_serial.sv - randomized self-checking bench for z4ml_inv_serial against an arithmetic model

module tb_z4ml_inv_serial;

    localparam int W = 3;
`ifdef Z4ML_INV_FAST_EN
    localparam int LAT = 2;
`else
    localparam int LAT = W + 2;
`endif
    localparam int TIMEOUT = 40;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W:0]   in_s;
    logic [W-1:0] in_b;
    logic         in_cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_a;
    logic         out_err;

    int checks;
    int errors;

    z4ml_inv_serial #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_s      (in_s),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_err   (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic void model(input int s, input int b, input int cin,
                                  output int a, output int err);
        int d;
        d   = s - b - cin;
        a   = d & ((1 << W) - 1);
        err = ((s < b + cin) || (d > (1 << W) - 1)) ? 1 : 0;
    endfunction

    // Called at a negedge with the block idle; returns at a negedge with the block idle again.
    task automatic run_op(input int s, input int b, input int cin,
                          input int exp_a, input int exp_err, input int stall);
        int lat;
        check("idle_ready", in_ready, 1);
        in_s     = (W+1)'(s);
        in_b     = W'(b);
        in_cin   = cin[0];
        in_valid = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < TIMEOUT) begin
            in_valid  = 1'($urandom);
            in_s      = (W+1)'($urandom);
            in_b      = W'($urandom);
            in_cin    = 1'($urandom);
            out_ready = 1'($urandom);
            @(negedge clk);
            lat++;
        end
        out_ready = 1'b0;
        check("latency", lat, LAT);
        if (!out_valid) return;
        check("out_a", out_a, exp_a);
        check("out_err", out_err, exp_err);
        check("busy_ready", in_ready, 0);
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1;
            in_s     = (W+1)'($urandom);
            in_b     = W'($urandom);
            @(negedge clk);
            check("stall_valid", out_valid, 1);
            check("stall_ready", in_ready, 0);
            check("stall_a", out_a, exp_a);
            check("stall_err", out_err, exp_err);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("drain_valid", out_valid, 0);
        check("drain_ready", in_ready, 1);
        check("hold_a", out_a, exp_a);
        check("hold_err", out_err, exp_err);
    endtask

    initial begin
        int ea;
        int ee;
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_s      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        out_ready = 1'b0;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_ready", in_ready, 1);
            check("rst_valid", out_valid, 0);
            check("rst_a", out_a, 0);
            check("rst_err", out_err, 0);
        end

        run_op(10, 3, 1, 6, 0, 0);
        run_op(15, 7, 1, 7, 0, 0);
        run_op(2, 5, 0, 5, 1, 0);
        run_op(15, 0, 0, 7, 1, 10);
        run_op(9, 2, 0, 7, 0, 0);

        // Abort on the second RUN cycle.
        in_s     = 4'd9;
        in_b     = 3'd2;
        in_cin   = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_valid", out_valid, 0);
        check("abort_ready", in_ready, 1);
        check("abort_a", out_a, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("abort_hold_valid", out_valid, 0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < LAT + 2; i++) begin
            @(negedge clk);
            check("abort_no_result", out_valid, 0);
        end
        run_op(9, 2, 0, 7, 0, 0);

        for (int s = 0; s < 16; s++) begin
            for (int b = 0; b < 8; b++) begin
                for (int c = 0; c < 2; c++) begin
                    model(s, b, c, ea, ee);
                    run_op(s, b, c, ea, ee, $urandom_range(0, 3));
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
